mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mips_pkg.sv | 18 +
 rtl/mul_div_unit.sv | 160 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// sequencer state type and iteration count.
package mips_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Operates on magnitudes for 32 steps, then fixes up signs in a final cycle.
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e state_q, state_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               negq_q, negq_d;   // product / quotient must be negated
  logic               negr_q, negr_d;   // remainder takes the dividend's sign
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dbzo_q, dbzo_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, trial;
  logic [2*WIDTH-1:0] res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == 5'd0) state_d = SIGN;
      SIGN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = done_q;
    div_by_zero = dbzo_q;
    hi          = hi_q;
    lo          = lo_q;
  end

  always_comb begin
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbzo_d    = 1'b0;
    signed_op = 1'b0;
    a_mag     = '0;
    b_mag     = '0;
    sum       = '0;
    trial     = '0;
    res       = '0;
    case (state_q)
      IDLE: begin
        if (we_hi) hi_d = wdata;
        if (we_lo) lo_d = wdata;
        if (start) begin
          signed_op = (op == MDU_MULT) || (op == MDU_DIV);
          a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
          b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
          div_d     = op[1];
          negq_d    = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
          negr_d    = signed_op && A[WIDTH-1];
          dbz_d     = op[1] && (B == '0);
          cnt_d     = 5'(MDU_ITER - 1);
          // Divide shifts the dividend up through acc; multiply shifts the multiplier down.
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - 5'd1;
        if (div_q) begin
          trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
          if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
      end
      SIGN: begin
        if (div_q) begin
          lo_d = dbz_q ? '1 : (negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
          hi_d = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          res  = negq_q ? -acc_q : acc_q;
          hi_d = res[2*WIDTH-1:WIDTH];
          lo_d = res[WIDTH-1:0];
        end
        done_d = 1'b1;
        dbzo_d = dbz_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dbz_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbzo_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dbz_q  <= dbz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      dbzo_q <= dbzo_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed results, latency, busy
// window, HI/LO writes, ignored restarts and mid-operation reset.
module tb_mul_div_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, we_hi, we_lo;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;
  int lat, bcyc, ndone;
  logic [31:0] hm;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start an op, scramble operands after E0, optionally disturb mid-run.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit whi,
                        output int latency, output int bc, output logic [31:0] hi_mid);
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    if (whi) begin we_hi = 1'b1; wdata = 32'h0000_0055; end
    @(posedge clk); #1;
    start = 1'b0; we_hi = 1'b0;
    A = ~a; B = b ^ 32'h5A5A_5A5A;
    bc = busy ? 1 : 0;
    latency = 0;
    hi_mid = hi;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (disturb && k == 10) begin
        start = 1'b1; op = MDU_DIVU; we_lo = 1'b1; wdata = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; we_lo = 1'b0;
      end
      if (k == 10) hi_mid = hi;
      if (busy) bc++;
      if (done) begin latency = k; break; end
    end
    start = 1'b0; we_lo = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
    we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    @(negedge clk) reset = 1'b0;

    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, bcyc, hm);
    chk("multu_latency", lat, 33);
    chk("multu_busy_cycles", bcyc, 33);
    chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    chk("multu_dbz", div_by_zero, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("hilo_hold", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(MDU_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0, lat, bcyc, hm);
    chk("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, lat, bcyc, hm);
    chk("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_latency", lat, 33);

    run_op(MDU_DIVU, 32'h0000_0007, 32'h0000_0000, 1'b0, 1'b0, lat, bcyc, hm);
    chk("dbz_latency", lat, 33);
    chk("dbz_hilo", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    chk("dbz_flag", div_by_zero, 1);
    @(posedge clk); #1;
    chk("dbz_flag_clears", div_by_zero, 0);

    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, bcyc, hm);
    chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    chk("div_ovf_dbz", div_by_zero, 0);

    run_op(MDU_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, lat, bcyc, hm);
    chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    @(negedge clk); we_hi = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1; we_hi = 1'b0;
    chk("mthi", {hi, lo}, {32'h1234_5678, 32'd14});

    run_op(MDU_MULTU, 32'd2, 32'd3, 1'b1, 1'b0, lat, bcyc, hm);
    chk("mthi_held_midrun", hm, 32'h1234_5678);
    chk("restart_latency", lat, 33);
    chk("mul_after_mthi", {hi, lo}, 64'h0000_0000_0000_0006);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("restart_ignored", ndone, 0);

    @(negedge clk); we_hi = 1'b1; we_lo = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk); we_hi = 1'b0; we_lo = 1'b0;
    op = MDU_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hilo", {hi, lo}, 64'h0);
    ndone = 0;
    repeat (2) begin @(posedge clk); #1; if (done) ndone++; end
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    run_op(MDU_MULTU, 32'd4, 32'd4, 1'b0, 1'b1, lat, bcyc, hm);
    chk("write_with_start", hm, 32'h0000_0055);
    chk("post_reset_latency", lat, 33);
    chk("post_reset_hilo", {hi, lo}, 64'h0000_0000_0000_0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
